// File: rtl/min_sum_tree16_pkg.sv
// Shared constants for the LDPC min-sum first/second-minimum trees.
package min_sum_tree16_pkg;
  localparam int NOB_DEF     = 4;
  localparam int MAG_W_DEF   = NOB_DEF + 1;
  localparam int IDX_W       = 4;
  localparam int IDX_W_TREE4 = 2;
endpackage

// File: rtl/min_sum_tree16_sorting.sv
// Two-input compare node shared by every min-sum tree: strict unsigned
// compare, ties keep input a.
module min_sum_sorting
  import min_sum_tree16_pkg::*;
#(
  parameter int W = MAG_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] min,
  output logic         cp
);

  assign cp  = (b < a);
  assign min = cp ? b : a;

endmodule

// File: rtl/min_sum_tree16.sv
// 16-input first/second-minimum finder: combinational compare tree (heap
// numbered, node n merges children 2n and 2n+1) feeding one output register.
module min_sum_tree16
  import min_sum_tree16_pkg::*;
#(
  parameter int NOB = NOB_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [NOB:0]     x0,
  input  logic [NOB:0]     x1,
  input  logic [NOB:0]     x2,
  input  logic [NOB:0]     x3,
  input  logic [NOB:0]     x4,
  input  logic [NOB:0]     x5,
  input  logic [NOB:0]     x6,
  input  logic [NOB:0]     x7,
  input  logic [NOB:0]     x8,
  input  logic [NOB:0]     x9,
  input  logic [NOB:0]     x10,
  input  logic [NOB:0]     x11,
  input  logic [NOB:0]     x12,
  input  logic [NOB:0]     x13,
  input  logic [NOB:0]     x14,
  input  logic [NOB:0]     x15,
  output logic             out_valid,
  output logic [NOB:0]     min1,
  output logic [NOB:0]     min2,
  output logic [IDX_W-1:0] min1_index
);

  localparam int W = NOB + 1;

  logic [W-1:0]     x_s   [16];
  logic [W-1:0]     m1_s  [1:15];
  logic [W-1:0]     m2_s  [1:15];
  logic [IDX_W-1:0] idx_s [1:15];

  assign x_s[0]  = x0;
  assign x_s[1]  = x1;
  assign x_s[2]  = x2;
  assign x_s[3]  = x3;
  assign x_s[4]  = x4;
  assign x_s[5]  = x5;
  assign x_s[6]  = x6;
  assign x_s[7]  = x7;
  assign x_s[8]  = x8;
  assign x_s[9]  = x9;
  assign x_s[10] = x10;
  assign x_s[11] = x11;
  assign x_s[12] = x12;
  assign x_s[13] = x13;
  assign x_s[14] = x14;
  assign x_s[15] = x15;

  // Leaves occupy heap nodes 8..15, leaf j pairs x(2j) with x(2j+1).
  for (genvar j = 0; j < 8; j++) begin : g_leaf
    logic leaf_cp_s;

    min_sum_sorting #(.W(W)) u_leaf (
      .a   (x_s[2*j]),
      .b   (x_s[2*j+1]),
      .min (m1_s[8+j]),
      .cp  (leaf_cp_s)
    );

    assign m2_s[8+j]  = leaf_cp_s ? x_s[2*j] : x_s[2*j+1];
    assign idx_s[8+j] = {{(IDX_W-1){1'b0}}, leaf_cp_s};
  end

  // Merge level lv adds index bit lv+1; the B child is the upper half.
  for (genvar lv = 0; lv < 3; lv++) begin : g_level
    for (genvar k = 0; k < (4 >> lv); k++) begin : g_node
      localparam int N = (4 >> lv) + k;

      logic         cp_s;
      logic [W-1:0] sel_a_s;
      logic [W-1:0] sel_b_s;
      logic         min2_cp_unused_s;

      min_sum_sorting #(.W(W)) u_min1 (
        .a   (m1_s[2*N]),
        .b   (m1_s[2*N+1]),
        .min (m1_s[N]),
        .cp  (cp_s)
      );

      assign sel_a_s = cp_s ? m1_s[2*N]   : m2_s[2*N];
      assign sel_b_s = cp_s ? m2_s[2*N+1] : m1_s[2*N+1];

      min_sum_sorting #(.W(W)) u_min2 (
        .a   (sel_a_s),
        .b   (sel_b_s),
        .min (m2_s[N]),
        .cp  (min2_cp_unused_s)
      );

      assign idx_s[N] = cp_s ? (idx_s[2*N+1] | IDX_W'(32'd1 << (lv + 1)))
                             : idx_s[2*N];
    end
  end

  // Output register: data held while in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      min1       <= '0;
      min2       <= '0;
      min1_index <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        min1       <= m1_s[1];
        min2       <= m2_s[1];
        min1_index <= idx_s[1];
      end
    end
  end

endmodule

// File: tb/tb_min_sum_tree16.sv
// Scoreboard bench for min_sum_tree16: directed corner vectors plus a
// random back-to-back stream checked against a sort-based model.
module tb_min_sum_tree16;

  typedef struct packed {
    logic [4:0] m1;
    logic [4:0] m2;
    logic [3:0] idx;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [4:0] x [16];
  logic       out_valid;
  logic [4:0] min1;
  logic [4:0] min2;
  logic [3:0] min1_index;

  exp_t q[$];
  exp_t last;
  int   checks;
  int   errors;

  min_sum_tree16 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .x0  (x[0]),  .x1  (x[1]),  .x2  (x[2]),  .x3  (x[3]),
    .x4  (x[4]),  .x5  (x[5]),  .x6  (x[6]),  .x7  (x[7]),
    .x8  (x[8]),  .x9  (x[9]),  .x10 (x[10]), .x11 (x[11]),
    .x12 (x[12]), .x13 (x[13]), .x14 (x[14]), .x15 (x[15]),
    .out_valid  (out_valid),
    .min1       (min1),
    .min2       (min2),
    .min1_index (min1_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model();
    exp_t       e;
    logic [4:0] s [16];
    logic [4:0] t;
    e.m1  = x[0];
    e.idx = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (x[k] < e.m1) begin
        e.m1  = x[k];
        e.idx = 4'(k);
      end
    end
    s = x;
    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < 15 - i; k++) begin
        if (s[k] > s[k+1]) begin
          t      = s[k];
          s[k]   = s[k+1];
          s[k+1] = t;
        end
      end
    end
    e.m2 = s[1];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 16; k++) x[k] = 5'($urandom_range(0, 31));
      tick();
      checks++;
      if ({out_valid, min1, min2, min1_index} !== 15'd0) begin
        errors++;
        $display("FAIL reset: got v=%0b min1=%0d min2=%0d idx=%0d, want all zero",
                 out_valid, min1, min2, min1_index);
      end
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    last     = '0;
  endtask

  task automatic test_descending();
    exp_t e;
    for (int k = 0; k < 16; k++) x[k] = 5'(31 - k);
    e = '{m1: 5'd16, m2: 5'd17, idx: 4'd15};
    q.push_back(e);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {min1, min2, min1_index} !== e) begin
      errors++;
      $display("FAIL descending: got v=%0b %0d/%0d/%0d, want v=1 %0d/%0d/%0d",
               out_valid, min1, min2, min1_index, e.m1, e.m2, e.idx);
    end
    last = e;
    for (int k = 0; k < 16; k++) x[k] = 5'd0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || {min1, min2, min1_index} !== last) begin
      errors++;
      $display("FAIL hold: got v=%0b %0d/%0d/%0d, want v=0 %0d/%0d/%0d",
               out_valid, min1, min2, min1_index, last.m1, last.m2, last.idx);
    end
  endtask

  task automatic test_two_low();
    exp_t e;
    for (int k = 0; k < 16; k++) x[k] = 5'd9;
    x[5]  = 5'd2;
    x[11] = 5'd4;
    e = '{m1: 5'd2, m2: 5'd4, idx: 4'd5};
    q.push_back(e);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {min1, min2, min1_index} !== e) begin
      errors++;
      $display("FAIL two_low: got v=%0b %0d/%0d/%0d, want v=1 %0d/%0d/%0d",
               out_valid, min1, min2, min1_index, e.m1, e.m2, e.idx);
    end
    last = e;
  endtask

  task automatic test_ties();
    exp_t e;
    for (int k = 0; k < 16; k++) x[k] = 5'd20;
    x[3]  = 5'd1;
    x[12] = 5'd1;
    e = '{m1: 5'd1, m2: 5'd1, idx: 4'd3};
    q.push_back(e);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {min1, min2, min1_index} !== e) begin
      errors++;
      $display("FAIL ties: got v=%0b %0d/%0d/%0d, want v=1 %0d/%0d/%0d",
               out_valid, min1, min2, min1_index, e.m1, e.m2, e.idx);
    end
    last = e;
  endtask

  task automatic test_all_equal();
    exp_t e;
    for (int k = 0; k < 16; k++) x[k] = 5'd7;
    e = '{m1: 5'd7, m2: 5'd7, idx: 4'd0};
    q.push_back(e);
    in_valid = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) x[k] = 5'd0;
    e = '{m1: 5'd0, m2: 5'd0, idx: 4'd0};
    q.push_back(e);
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {min1, min2, min1_index} !== e) begin
      errors++;
      $display("FAIL all_seven: got v=%0b %0d/%0d/%0d, want v=1 %0d/%0d/%0d",
               out_valid, min1, min2, min1_index, e.m1, e.m2, e.idx);
    end
    tick();
    in_valid = 1'b0;
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {min1, min2, min1_index} !== e) begin
      errors++;
      $display("FAIL all_zero: got v=%0b %0d/%0d/%0d, want v=1 %0d/%0d/%0d",
               out_valid, min1, min2, min1_index, e.m1, e.m2, e.idx);
    end
    last = e;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic v;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, min1, min2, min1_index} !== 15'd0) begin
          errors++;
          $display("FAIL async_reset: got v=%0b %0d/%0d/%0d, want all zero",
                   out_valid, min1, min2, min1_index);
        end
        q.delete();
        last     = '0;
        in_valid = 1'b1;
        tick();
        rst_n = 1'b1;
      end
      v = (i == 49)      ? 1'b1 :
          (i == 50)      ? 1'b0 :
          ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < 16; k++) x[k] = 5'($urandom_range(0, 3));
      end else begin
        for (int k = 0; k < 16; k++) x[k] = 5'($urandom_range(0, 31));
      end
      if (v) q.push_back(model());
      in_valid = v;
      tick();
      checks++;
      if (out_valid !== v) begin
        errors++;
        $display("FAIL valid_%0d: got %0b, want %0b", i, out_valid, v);
      end
      if (v) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_%0d: got empty queue, want one entry", i);
        end else begin
          e = q.pop_front();
          if ({min1, min2, min1_index} !== e) begin
            errors++;
            $display("FAIL random_%0d: got %0d/%0d/%0d, want %0d/%0d/%0d",
                     i, min1, min2, min1_index, e.m1, e.m2, e.idx);
          end
          last = e;
        end
      end else begin
        checks++;
        if ({min1, min2, min1_index} !== last) begin
          errors++;
          $display("FAIL hold_%0d: got %0d/%0d/%0d, want %0d/%0d/%0d",
                   i, min1, min2, min1_index, last.m1, last.m2, last.idx);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) x[k] = 5'd0;
    last = '0;
    test_reset();
    test_descending();
    test_two_low();
    test_ties();
    test_all_equal();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
